mult_div_unit: RTL and testbench

// - E-stage multiply/divide sequencer for the 5-stage MIPS pipeline; owns the HI/LO registers.
// - Accepts mult/multu/div/divu/mthi/mtlo from the E stage and models fixed multi-cycle latency with a busy counter.
// - Produces the MD stall request that the Stall unit ORs into its stall.
// - That stall holds PC and the D register and clears E while a mfhi/mflo/md instruction waits in D.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_counter.sv | 29 ++
 rtl/mult_div_unit.sv | 128 ++++++++++++
 tb/tb_mult_div_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Purpose: shared encodings and default latencies for the multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_pkg;

  // Operation selector carried on MDOp.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd7
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // mult/multu/div/divu all have bit 2 clear; mthi/mtlo/none have it set.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_counter.sv
// Purpose: loadable down-counter that flags the last cycle of an operation.
// Latency: load takes effect at the next edge; o_done is combinational from the count.
// Backpressure: none; counts down every cycle until it reaches zero.
// Ports: i_clk, i_reset (sync, active-high), i_load/i_load_val (start value), o_done (count == 1).
module md_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Purpose: E-stage multiply/divide sequencer owning HI/LO, with MD stall request.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo one edge.
// Backpressure: Stall_MD holds an md instruction in D while an op starts or runs.
// Ports: Clk, Reset (sync, active-high); Start/MDOp/A/B from E; D_is_md from D;
//        Busy, Stall_MD, HI, LO out.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_is_md,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t   r_state, w_state_nxt;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [2:0]  r_op;

  logic             w_accept, w_done, w_commit, w_res_wr;
  logic [CNT_W-1:0] w_load_val;
  logic [31:0]      w_res_hi, w_res_lo;

  // Start is only honoured from IDLE; a Start during RUN leaves the in-flight op alone.
  assign w_accept   = Start && (r_state == IDLE) && md_is_arith(MDOp);
  assign w_load_val = md_is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  assign w_commit   = (r_state == RUN) && w_done;

  md_counter #(.W(CNT_W)) u_cnt (
    .i_clk      (Clk),
    .i_reset    (Reset),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_done)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arithmetic from the latched operands.
  logic signed [63:0] w_a_sx, w_b_sx, w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_a_s, w_b_s, w_q_s, w_r_s;
  logic        [31:0] w_b_nz, w_q_u, w_r_u;
  logic               w_b_zero, w_ovf;

  assign w_a_sx   = {{32{r_a[31]}}, r_a};
  assign w_b_sx   = {{32{r_b[31]}}, r_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Divisor forced non-zero so the divider never sees /0; the result is discarded then anyway.
  assign w_b_zero = (r_b == 32'd0);
  assign w_b_nz   = w_b_zero ? 32'd1 : r_b;
  assign w_a_s    = r_a;
  assign w_b_s    = w_b_nz;
  assign w_ovf    = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_q_s    = w_ovf ? 32'sh8000_0000 : (w_a_s / w_b_s);
  assign w_r_s    = w_ovf ? 32'sd0 : (w_a_s % w_b_s);
  assign w_q_u    = r_a / w_b_nz;
  assign w_r_u    = r_a % w_b_nz;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_wr = 1'b0;
    case (r_op)
      MD_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; w_res_wr = 1'b1; end
      MD_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; w_res_wr = 1'b1; end
      MD_DIV:   begin w_res_hi = w_r_s; w_res_lo = w_q_s; w_res_wr = !w_b_zero; end
      MD_DIVU:  begin w_res_hi = w_r_u; w_res_lo = w_q_u; w_res_wr = !w_b_zero; end
      default:  w_res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= MD_NONE;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= A;
        r_b  <= B;
        r_op <= MDOp;
      end
      // Commit only happens in RUN and moves only in IDLE, so they never collide.
      if (w_commit && w_res_wr) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if ((r_state == IDLE) && !Start) begin
        if (MDOp == MD_MTHI) r_hi <= A;
        if (MDOp == MD_MTLO) r_lo <= A;
      end
    end
  end

  assign Busy     = (r_state == RUN);
  assign Stall_MD = D_is_md & (Start | Busy);
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import md_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, D_is_md;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Stall_MD;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .D_is_md(D_is_md), .Busy(Busy), .Stall_MD(Stall_MD), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       lbl;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  bit   mon_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Monitor: a result is presented when Busy falls, or when HI/LO move while idle.
  logic        prev_busy = 1'b0;
  logic [31:0] prev_hi = '0, prev_lo = '0;
  int          busy_cnt = 0;
  exp_t        mon_e;

  always @(negedge Clk) begin
    if (!mon_en) begin
      busy_cnt = 0;
    end else if (Busy) begin
      busy_cnt++;
      if (HI !== prev_hi || LO !== prev_lo) check("hilo_moved_while_busy", HI, prev_hi);
    end else if (prev_busy || HI !== prev_hi || LO !== prev_lo) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: HI=0x%08h LO=0x%08h with nothing pending", HI, LO);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.lbl, " HI"}, HI, mon_e.hi);
        check({mon_e.lbl, " LO"}, LO, mon_e.lo);
        check({mon_e.lbl, " busy_cycles"}, 32'(busy_cnt), 32'(mon_e.n));
      end
      busy_cnt = 0;
    end
    prev_busy = Busy;
    prev_hi   = HI;
    prev_lo   = LO;
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input string lbl, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic d, input logic [31:0] eh,
                        input logic [31:0] el, input int n, input bit disturb);
    exp_t e;
    int   stall_cnt = 0;
    bit   done = 1'b0;
    e.lbl = lbl; e.n = n; e.hi = eh; e.lo = el;
    exp_q.push_back(e);
    Start = 1'b1; MDOp = op; A = a; B = b; D_is_md = d;
    @(negedge Clk);
    check({lbl, " stall_at_start"}, 32'(Stall_MD), 32'(d));
    @(posedge Clk); #1;
    // Scramble inputs: the in-flight op must use the captured operands.
    Start = 1'b0; MDOp = MD_NONE; A = 32'h5A5A_5A5A; B = 32'hA5A5_A5A5;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (!Busy) begin done = 1'b1; break; end
      if (Stall_MD) stall_cnt++;
      if (disturb) begin
        if (i == 1)      begin Start = 1'b1; MDOp = MD_MULTU; A = 32'd5; B = 32'd5; end
        else if (i == 2) begin Start = 1'b0; MDOp = MD_MTHI; A = 32'hDEAD_0000; end
        else if (i == 3) MDOp = MD_NONE;
      end
    end
    check({lbl, " busy_ended"}, 32'(done), 32'd1);
    check({lbl, " stall_cycles"}, 32'(stall_cnt), d ? 32'(n) : 32'd0);
    check({lbl, " stall_after"}, 32'(Stall_MD), 32'd0);
    D_is_md = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic mt_op(input string lbl, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.lbl = lbl; e.n = 0; e.hi = eh; e.lo = el;
    exp_q.push_back(e);
    MDOp = op; A = a;
    @(posedge Clk); #1;
    MDOp = MD_NONE;
    @(negedge Clk);
    check({lbl, " busy"}, 32'(Busy), 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    int busy_seen;
    Reset = 1'b1; Start = 1'b0; MDOp = MD_NONE; A = '0; B = '0; D_is_md = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset Stall_MD", 32'(Stall_MD), 32'd0);
    @(posedge Clk); #1;
    mon_en = 1'b1;

    run_op("mult -2*3",      MD_MULT,  32'hFFFF_FFFE, 32'd3,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  1'b0);
    run_op("multu ffff*2",   MD_MULTU, 32'hFFFF_FFFF, 32'd2,        1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 5,  1'b0);
    run_op("div -7/2",       MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
    run_op("divu 7/0",       MD_DIVU,  32'd7,         32'd0,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    run_op("div min/-1",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 10, 1'b0);
    mt_op ("mthi",           MD_MTHI,  32'h1234_5678, 32'h1234_5678, 32'h8000_0000);
    mt_op ("mtlo",           MD_MTLO,  32'h0000_ABCD, 32'h1234_5678, 32'h0000_ABCD);
    run_op("divu 100/7",     MD_DIVU,  32'd100,       32'd7,        1'b0, 32'd2,         32'd14,        10, 1'b0);
    run_op("mult max*max",   MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 5,  1'b0);
    run_op("div 7/-2",       MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b0);
    run_op("multu ffff^2",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5,  1'b0);

    // Reset in the third busy cycle of a div: result must be discarded.
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = MD_NONE;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("busy before reset", 32'(Busy), 32'd1);
    mon_en = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("midop reset Busy", 32'(Busy), 32'd0);
    check("midop reset HI", HI, 32'd0);
    check("midop reset LO", LO, 32'd0);
    @(posedge Clk); #1;
    mon_en = 1'b1;
    busy_seen = 0;
    repeat (15) begin
      @(negedge Clk);
      if (Busy) busy_seen++;
    end
    check("post reset busy cycles", 32'(busy_seen), 32'd0);
    check("post reset HI", HI, 32'd0);
    check("post reset LO", LO, 32'd0);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
